te_radio_seq: RTL and testbench
===============================

TE_RADIO_SEQ -- requirements
Module: te_radio_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth; legal range 2..4.
REQ-002 SHALL have parameter NUM_RX, default 2, number of receive-enable channels; legal range 1..8.
REQ-003 SHALL have parameter SETTLE_W, default 8, width of the settle-count input and counter.
REQ-004 SHALL have port ck  in  1  sole clock; all flops on rising edge.
REQ-005 SHALL have port arst  in  1  asynchronous reset, active-high, clears every flop.
REQ-006 SHALL have port pll_settled  in  1  asynchronous PLL-settled indication.
REQ-007 SHALL have port rx_en_req  in  NUM_RX  asynchronous per-channel receive-enable requests.
REQ-008 SHALL have port settle_cycles  in  SETTLE_W  quasi-static required stable-high count.
REQ-009 SHALL have port clr_stats  in  1  synchronous clear of lost_count.
REQ-010 SHALL have port radio_enable  out  1  registered radio enable.
REQ-011 SHALL have port rx_en  out  NUM_RX  registered per-channel receive enables.
REQ-012 SHALL have port pll_lost  out  1  one-cycle registered pulse on PLL loss while enabled.
REQ-013 SHALL have port state  out  2  current FSM state: IDLE=00, SETTLE=01, ACTIVE=10, DRAIN=11.
REQ-014 SHALL have port lost_count  out  8  saturating count of PLL-loss events.

Function
REQ-015 SHALL pass pll_settled and each rx_en_req bit through an independent SYNC_STAGES-flop synchronizer; last-stage outputs are pll_s and rx_s.
REQ-016 SHALL compute N = settle_cycles, or 1 when settle_cycles is 0, and capture N into an internal target register every cycle in IDLE; target is frozen outside IDLE.
REQ-017 IDLE: radio_enable=0, rx_en=0, settle counter=0. On an edge with pll_s=1, go to ACTIVE if N=1, else to SETTLE with counter=1.
REQ-018 SETTLE: on an edge with pll_s=0, go to IDLE and clear the counter. On an edge with pll_s=1, increment the counter, and go to ACTIVE when the incremented value equals N.
REQ-019 Latency: radio_enable SHALL rise exactly SYNC_STAGES+N edges after the first edge at which pll_settled is sampled high, provided pll_settled stays high throughout.
REQ-020 radio_enable SHALL be 1 in ACTIVE and DRAIN only, and SHALL be driven from a flop updated in the same edge as the state register.
REQ-021 ACTIVE with pll_s=1: rx_en SHALL register rx_s every edge. rx_en stays 0 at the edge that enters ACTIVE, so rx_en never rises before radio_enable.
REQ-022 ACTIVE with pll_s=0: go to DRAIN, rx_en<=0, pll_lost<=1, and lost_count increments saturating at 255.
REQ-023 DRAIN lasts exactly one cycle: rx_en=0, radio_enable=1, pll_lost<=0; next state IDLE (radio_enable<=0) regardless of pll_s. rx_en thus falls one cycle before radio_enable.
REQ-024 pll_lost SHALL be high for exactly one cycle per loss event; it is never asserted from IDLE or SETTLE.
REQ-025 clr_stats=1 SHALL set lost_count to 0 at the next edge, and takes priority over a simultaneous increment.
REQ-026 Changes of rx_en_req outside ACTIVE SHALL have no effect on rx_en.

Reset
REQ-027 While arst=1, and immediately on its assertion: all synchronizer flops, counter and target SHALL be 0; state=IDLE; radio_enable=0, rx_en=0, pll_lost=0, lost_count=0.
REQ-028 Reset asserted in any state, including mid-SETTLE or ACTIVE, SHALL abort the sequence. After release the block restarts from IDLE and requires full synchronizer plus N-cycle qualification.

Verification
REQ-029 Nominal (SYNC_STAGES=2, settle_cycles=4): pll_settled 0->1 before edge 1 -> radio_enable rises after edge 6. rx_en_req=2'b11 held -> rx_en=2'b11 after edge 7.
REQ-030 Glitch (settle_cycles=4): pll_s high for 3 sampled edges, then low -> state returns to IDLE; radio_enable, rx_en and pll_lost stay 0.
REQ-031 Loss in ACTIVE: drop pll_settled -> rx_en=0 and pll_lost=1 for one cycle, with state=DRAIN; radio_enable=0 one cycle later; lost_count increments by 1.
REQ-032 settle_cycles=0 -> behaves as N=1: radio_enable rises SYNC_STAGES+1 edges after pll_settled is sampled high.
REQ-033 Statistics: force 256 loss events -> lost_count=255. Then clr_stats coincident with a loss event -> lost_count=0, and pll_lost still pulses.
REQ-034 Reset mid-ACTIVE with rx_en=2'b01 -> all outputs 0 immediately (asynchronously), state=00. After release, with pll_settled high, re-qualification takes SYNC_STAGES+N edges.

Source files
------------

// File: rtl/te_radio_seq_if.sv
// Bus between the radio power-up sequencer and its controller: PLL status,
// receive-enable requests, settle configuration and the sequencer outputs.
interface te_radio_seq_if #(
    parameter int NUM_RX   = 2,
    parameter int SETTLE_W = 8
);
    logic                pll_settled;
    logic [NUM_RX-1:0]   rx_en_req;
    logic [SETTLE_W-1:0] settle_cycles;
    logic                clr_stats;
    logic                radio_enable;
    logic [NUM_RX-1:0]   rx_en;
    logic                pll_lost;
    logic [1:0]          state;
    logic [7:0]          lost_count;

    // Controller side: drives requests and configuration, observes status.
    modport master (
        output pll_settled, rx_en_req, settle_cycles, clr_stats,
        input  radio_enable, rx_en, pll_lost, state, lost_count
    );

    // Sequencer side.
    modport slave (
        input  pll_settled, rx_en_req, settle_cycles, clr_stats,
        output radio_enable, rx_en, pll_lost, state, lost_count
    );
endinterface

// File: rtl/te_radio_seq.sv
// Radio power-up sequencer. Qualifies an asynchronous PLL-settled flag for
// N consecutive synchronized cycles before enabling the radio, gates the
// per-channel receive enables behind the radio enable, and tears down in a
// fixed order (rx_en first, radio_enable one cycle later) on PLL loss.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | radio off; tracks settle target; waits for synchronized PLL
//   SETTLE | counting consecutive PLL-high cycles up to the frozen target
//   ACTIVE | radio on; rx_en follows synchronized requests
//   DRAIN  | one-cycle teardown after PLL loss; rx_en already low
module te_radio_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_RX      = 2,
    parameter int SETTLE_W    = 8
) (
    input  logic           ck,
    input  logic           arst,
    te_radio_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_DRAIN  = 2'b11
    } state_t;

    localparam logic [SETTLE_W-1:0] ONE = SETTLE_W'(1);

    logic [SYNC_STAGES-1:0]             r_pll_sync;
    logic [SYNC_STAGES-1:0][NUM_RX-1:0] r_rx_sync;

    state_t              r_state;
    logic [SETTLE_W-1:0] r_cnt;
    logic [SETTLE_W-1:0] r_target;
    logic                r_radio_enable;
    logic [NUM_RX-1:0]   r_rx_en;
    logic                r_pll_lost;
    logic [7:0]          r_lost_count;

    logic                w_pll_s;
    logic [NUM_RX-1:0]   w_rx_s;
    logic [SETTLE_W-1:0] w_n;
    logic [SETTLE_W-1:0] w_cnt_inc;

    assign w_pll_s   = r_pll_sync[SYNC_STAGES-1];
    assign w_rx_s    = r_rx_sync[SYNC_STAGES-1];
    // A zero setting would never terminate the count, so treat it as one.
    assign w_n       = (bus.settle_cycles == '0) ? ONE : bus.settle_cycles;
    assign w_cnt_inc = r_cnt + ONE;

    // Independent multi-flop synchronizers for the PLL flag and each request bit.
    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            r_pll_sync <= '0;
            r_rx_sync  <= '0;
        end else begin
            r_pll_sync <= {r_pll_sync[SYNC_STAGES-2:0], bus.pll_settled};
            r_rx_sync  <= {r_rx_sync[SYNC_STAGES-2:0], bus.rx_en_req};
        end
    end

    // Sequencer FSM with registered outputs and loss statistics.
    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_target       <= '0;
            r_radio_enable <= 1'b0;
            r_rx_en        <= '0;
            r_pll_lost     <= 1'b0;
            r_lost_count   <= '0;
        end else begin
            r_pll_lost <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_target       <= w_n;
                    r_radio_enable <= 1'b0;
                    r_rx_en        <= '0;
                    r_cnt          <= '0;
                    if (w_pll_s) begin
                        if (w_n == ONE) begin
                            r_state        <= ST_ACTIVE;
                            r_radio_enable <= 1'b1;
                        end else begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= ONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!w_pll_s) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_target) begin
                            r_state        <= ST_ACTIVE;
                            r_radio_enable <= 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_pll_s) begin
                        r_rx_en <= w_rx_s;
                    end else begin
                        r_state    <= ST_DRAIN;
                        r_rx_en    <= '0;
                        r_pll_lost <= 1'b1;
                        if (r_lost_count != 8'hFF) begin
                            r_lost_count <= r_lost_count + 8'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_rx_en        <= '0;
                    r_radio_enable <= 1'b0;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // Clearing wins over a same-cycle loss increment.
            if (bus.clr_stats) begin
                r_lost_count <= '0;
            end
        end
    end

    assign bus.radio_enable = r_radio_enable;
    assign bus.rx_en        = r_rx_en;
    assign bus.pll_lost     = r_pll_lost;
    assign bus.state        = r_state;
    assign bus.lost_count   = r_lost_count;

endmodule

// File: tb/tb_te_radio_seq.sv
// Directed bench for te_radio_seq with default parameters
// (SYNC_STAGES=2, NUM_RX=2, SETTLE_W=8). Edge numbers in comments count
// rising edges from the first one that samples the new pll_settled value.
module tb_te_radio_seq;

    logic ck;
    logic arst;
    int   n_checks;
    int   n_errors;

    te_radio_seq_if #(.NUM_RX(2), .SETTLE_W(8)) bus ();

    te_radio_seq #(
        .SYNC_STAGES(2),
        .NUM_RX     (2),
        .SETTLE_W   (8)
    ) dut (
        .ck  (ck),
        .arst(arst),
        .bus (bus)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ck);
            #1;
        end
    endtask

    initial begin
        n_checks               = 0;
        n_errors               = 0;
        arst                   = 1'b1;
        bus.pll_settled        = 1'b0;
        bus.rx_en_req          = 2'b00;
        bus.settle_cycles      = 8'd4;
        bus.clr_stats          = 1'b0;

        // Reset state
        tick(3);
        check("rst_state",  bus.state, 2'b00);
        check("rst_radio",  bus.radio_enable, 1'b0);
        check("rst_rx",     bus.rx_en, 2'b00);
        check("rst_lost",   bus.pll_lost, 1'b0);
        check("rst_lcnt",   bus.lost_count, 8'd0);
        arst = 1'b0;
        tick(2);

        // Nominal power-up, N=4: enable after edge 6, rx_en after edge 7
        bus.rx_en_req   = 2'b11;
        bus.pll_settled = 1'b1;
        tick(5);
        check("nom_radio_e5", bus.radio_enable, 1'b0);
        check("nom_state_e5", bus.state, 2'b01);
        tick(1);
        check("nom_radio_e6", bus.radio_enable, 1'b1);
        check("nom_state_e6", bus.state, 2'b10);
        check("nom_rx_e6",    bus.rx_en, 2'b00);
        tick(1);
        check("nom_rx_e7",    bus.rx_en, 2'b11);

        // Request change propagates through sync (2) plus register (1)
        bus.rx_en_req = 2'b01;
        tick(2);
        check("req_rx_e2", bus.rx_en, 2'b11);
        tick(1);
        check("req_rx_e3", bus.rx_en, 2'b01);

        // Loss in ACTIVE: DRAIN at edge 3, IDLE at edge 4
        bus.pll_settled = 1'b0;
        tick(2);
        check("loss_state_e2", bus.state, 2'b10);
        check("loss_rx_e2",    bus.rx_en, 2'b01);
        tick(1);
        check("loss_state_e3", bus.state, 2'b11);
        check("loss_rx_e3",    bus.rx_en, 2'b00);
        check("loss_plost_e3", bus.pll_lost, 1'b1);
        check("loss_radio_e3", bus.radio_enable, 1'b1);
        check("loss_lcnt_e3",  bus.lost_count, 8'd1);
        tick(1);
        check("loss_state_e4", bus.state, 2'b00);
        check("loss_radio_e4", bus.radio_enable, 1'b0);
        check("loss_plost_e4", bus.pll_lost, 1'b0);
        tick(3);

        // Glitch: pll_s high at edges 3..5, low at edge 6
        bus.pll_settled = 1'b1;
        tick(3);
        bus.pll_settled = 1'b0;
        bus.rx_en_req   = 2'b10;
        tick(2);
        check("gl_state_e5", bus.state, 2'b01);
        check("gl_radio_e5", bus.radio_enable, 1'b0);
        tick(1);
        check("gl_state_e6", bus.state, 2'b00);
        check("gl_radio_e6", bus.radio_enable, 1'b0);
        check("gl_rx_e6",    bus.rx_en, 2'b00);
        check("gl_plost_e6", bus.pll_lost, 1'b0);
        check("gl_lcnt_e6",  bus.lost_count, 8'd1);
        tick(3);

        // settle_cycles = 0 behaves as N=1: enable after edge 3
        bus.settle_cycles = 8'd0;
        bus.pll_settled   = 1'b1;
        tick(2);
        check("n0_radio_e2", bus.radio_enable, 1'b0);
        tick(1);
        check("n0_radio_e3", bus.radio_enable, 1'b1);
        check("n0_state_e3", bus.state, 2'b10);

        // 255 more losses, 256 in total -> saturates at 255
        for (int i = 0; i < 255; i++) begin
            bus.pll_settled = 1'b0;
            tick(4);
            bus.pll_settled = 1'b1;
            tick(3);
        end
        check("sat_state", bus.state, 2'b10);
        check("sat_lcnt",  bus.lost_count, 8'd255);

        // One more loss with clr_stats on the same edge
        bus.pll_settled = 1'b0;
        tick(2);
        bus.clr_stats = 1'b1;
        tick(1);
        bus.clr_stats = 1'b0;
        check("clr_state", bus.state, 2'b11);
        check("clr_plost", bus.pll_lost, 1'b1);
        check("clr_lcnt",  bus.lost_count, 8'd0);
        tick(1);
        check("clr_idle",  bus.state, 2'b00);
        tick(3);

        // Reset mid-ACTIVE with rx_en=01, then full re-qualification
        bus.settle_cycles = 8'd4;
        bus.rx_en_req     = 2'b01;
        bus.pll_settled   = 1'b1;
        tick(7);
        check("ra_rx_pre",    bus.rx_en, 2'b01);
        check("ra_radio_pre", bus.radio_enable, 1'b1);
        #2;
        arst = 1'b1;
        #1;
        check("ra_state",  bus.state, 2'b00);
        check("ra_radio",  bus.radio_enable, 1'b0);
        check("ra_rx",     bus.rx_en, 2'b00);
        check("ra_plost",  bus.pll_lost, 1'b0);
        check("ra_lcnt",   bus.lost_count, 8'd0);
        tick(1);
        arst = 1'b0;
        tick(5);
        check("rq_radio_e5", bus.radio_enable, 1'b0);
        check("rq_state_e5", bus.state, 2'b01);
        tick(1);
        check("rq_radio_e6", bus.radio_enable, 1'b1);
        check("rq_rx_e6",    bus.rx_en, 2'b00);
        tick(1);
        check("rq_rx_e7",    bus.rx_en, 2'b01);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
